// File: rtl/zigzag_serializer.sv
`default_nettype none
// ============================================================================
// Module      : zigzag_serializer
// Description : Ping-pong buffered 8x8 block capture, streamed out one
//               coefficient per handshake in JPEG zigzag order.
// Revision    : 1.0 - initial release
// ============================================================================
module zigzag_serializer #(
    parameter int DATA_W = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_block [8][8],
    output logic                     in_ready,
    output logic                     coef_valid,
    input  logic                     coef_ready,
    output logic signed [DATA_W-1:0] coef_out,
    output logic [5:0]               coef_idx,
    output logic                     coef_first,
    output logic                     coef_last,
    output logic                     overflow
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_STREAM = 1'b1;

    // Zigzag index -> raster position (row*8 + col)
    localparam logic [5:0] c_ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic signed [DATA_W-1:0] r_bank [2][8][8];
    logic [1:0]               r_full;
    logic                     r_wr_bank;
    logic                     r_rd_bank;
    logic [5:0]               r_cnt;
    logic                     r_overflow;
    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;

    logic                     w_cap;
    logic                     w_fire;
    logic                     w_end;
    logic                     w_rd_avail;
    logic                     w_other_avail;
    logic [5:0]               w_pos;

    assign in_ready  = !rst && !(r_full[0] && r_full[1]);
    assign w_cap     = in_valid && in_ready;
    assign w_fire    = coef_valid && coef_ready;
    assign w_end     = w_fire && (r_cnt == 6'd63);
    assign w_pos     = c_ZZ[r_cnt];
    assign overflow  = r_overflow;

    // A capture landing this cycle counts as available so streaming starts
    // one cycle after capture and block-to-block handover has no bubble.
    assign w_rd_avail    = r_full[r_rd_bank]  || (w_cap && (r_wr_bank == r_rd_bank));
    assign w_other_avail = r_full[~r_rd_bank] || (w_cap && (r_wr_bank != r_rd_bank));

    always_ff @(posedge clk) begin
        if (w_cap) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    r_bank[r_wr_bank][r][c] <= in_block[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_cnt      <= 6'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_cap) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
            end
            if (w_end) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
            if (w_fire) begin
                r_cnt <= r_cnt + 6'd1;
            end
            if (in_valid && !in_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rd_avail) begin
                    w_state_nxt = c_ST_STREAM;
                end
            end
            c_ST_STREAM: begin
                if (w_end && !w_other_avail) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        coef_valid = 1'b0;
        coef_out   = '0;
        coef_idx   = 6'd0;
        coef_first = 1'b0;
        coef_last  = 1'b0;
        if (!rst && (r_state == c_ST_STREAM)) begin
            coef_valid = 1'b1;
            coef_out   = r_bank[r_rd_bank][w_pos[5:3]][w_pos[2:0]];
            coef_idx   = r_cnt;
            coef_first = (r_cnt == 6'd0);
            coef_last  = (r_cnt == 6'd63);
        end
    end

endmodule
`default_nettype wire
